alu_issue_ctrl: RTL and testbench

Instruction-issue controller that acts as the initiator for the 32-bit floating-point/logic `alu`. It accepts one register-to-register instruction at a time over a valid/ready handshake and reads both operands from an internal 8 x 32 register file. It drives `OpCode`/`x1`/`x2` into the ALU, waits a fixed ALU latency, then writes `x3` back to the destination register. It sits between the host/decoder and the `alu`, and replaces the hand-driven stimulus used so far.

---
 rtl/alu_issue_ctrl_pkg.sv | 31 +++
 rtl/alu_issue_ctrl_if.sv | 37 +++
 rtl/alu_issue_ctrl_regfile.sv | 44 ++++
 rtl/alu_issue_ctrl.sv | 105 ++++++++++
 tb/tb_alu_issue_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: operand/opcode types,
// opcode encodings, legality check and the controller state encoding.
package alu_pkg;

  typedef logic [2:0]  opcode_t;
  typedef logic [2:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  localparam opcode_t OP_FADD = 3'b000;
  localparam opcode_t OP_FSUB = 3'b001;
  localparam opcode_t OP_FMUL = 3'b011;
  localparam opcode_t OP_AND  = 3'b100;
  localparam opcode_t OP_OR   = 3'b101;
  localparam opcode_t OP_XOR  = 3'b110;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // 010 and 111 have no ALU operation behind them.
  function automatic logic is_legal_op(input opcode_t op);
    logic legal;
    case (op)
      OP_FADD, OP_FSUB, OP_FMUL, OP_AND, OP_OR, OP_XOR: legal = 1'b1;
      default:                                          legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of instruction handshake, host register port and ALU drive/return.
// slave is the controller side; master is the host plus ALU environment.
interface alu_issue_ctrl_if;
  import alu_pkg::*;

  logic      instr_valid;
  logic      instr_ready;
  opcode_t   instr_op;
  reg_addr_t instr_rs1;
  reg_addr_t instr_rs2;
  reg_addr_t instr_rd;
  logic      wr_en;
  reg_addr_t wr_addr;
  word_t     wr_data;
  reg_addr_t rd_addr;
  word_t     rd_data;
  opcode_t   alu_op;
  word_t     alu_x1;
  word_t     alu_x2;
  word_t     alu_x3;
  logic      done;
  logic      illegal;
  word_t     result;

  modport master (
    output instr_valid, instr_op, instr_rs1, instr_rs2, instr_rd,
    output wr_en, wr_addr, wr_data, rd_addr, alu_x3,
    input  instr_ready, rd_data, alu_op, alu_x1, alu_x2, done, illegal, result
  );

  modport slave (
    input  instr_valid, instr_op, instr_rs1, instr_rs2, instr_rd,
    input  wr_en, wr_addr, wr_data, rd_addr, alu_x3,
    output instr_ready, rd_data, alu_op, alu_x1, alu_x2, done, illegal, result
  );

endinterface

// File: rtl/alu_issue_ctrl_regfile.sv
// Register file: three combinational read ports (rs1, rs2, host) and two
// write ports (host, ALU writeback). Writeback wins on an address collision.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int unsigned NREG = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  input  reg_addr_t ra1_i,
  output word_t     rd1_o,
  input  reg_addr_t ra2_i,
  output word_t     rd2_o,
  input  reg_addr_t ra3_i,
  output word_t     rd3_o,
  input  logic      hw_en_i,
  input  reg_addr_t hw_addr_i,
  input  word_t     hw_data_i,
  input  logic      wb_en_i,
  input  reg_addr_t wb_addr_i,
  input  word_t     wb_data_i
);

  word_t mem_q [NREG];

  // Addresses beyond NREG read as zero when the file is built smaller than 8.
  assign rd1_o = (32'(ra1_i) < NREG) ? mem_q[ra1_i] : '0;
  assign rd2_o = (32'(ra2_i) < NREG) ? mem_q[ra2_i] : '0;
  assign rd3_o = (32'(ra3_i) < NREG) ? mem_q[ra3_i] : '0;

  for (genvar gi = 0; gi < NREG; gi++) begin : g_entry
    // Per-entry update: writeback has priority over the host write.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_q[gi] <= '0;
      end else if (wb_en_i && (wb_addr_i == 3'(gi))) begin
        mem_q[gi] <= wb_data_i;
      end else if (hw_en_i && (hw_addr_i == 3'(gi))) begin
        mem_q[gi] <= hw_data_i;
      end
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts one instruction at a time, reads operands from
// the register file, drives the ALU, waits ALU_LAT cycles and writes back.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned ALU_LAT = 2,
  parameter int unsigned NREG    = 8
) (
  input logic              clk,
  input logic              rst_n,
  alu_issue_ctrl_if.slave  bus
);

  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT);

  state_e     state_q;
  logic [3:0] cnt_q;
  reg_addr_t  rd_q;
  opcode_t    alu_op_q;
  word_t      alu_x1_q;
  word_t      alu_x2_q;
  word_t      result_q;
  logic       done_q;
  logic       illegal_q;

  word_t      rs1_data;
  word_t      rs2_data;
  logic       wb_en;

  // The ALU result is captured on the last counted WAIT edge.
  assign wb_en = (state_q == ST_WAIT) && (cnt_q == 4'd1);

  alu_regfile #(.NREG(NREG)) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .ra1_i     (bus.instr_rs1),
    .rd1_o     (rs1_data),
    .ra2_i     (bus.instr_rs2),
    .rd2_o     (rs2_data),
    .ra3_i     (bus.rd_addr),
    .rd3_o     (bus.rd_data),
    .hw_en_i   (bus.wr_en),
    .hw_addr_i (bus.wr_addr),
    .hw_data_i (bus.wr_data),
    .wb_en_i   (wb_en),
    .wb_addr_i (rd_q),
    .wb_data_i (bus.alu_x3)
  );

  // Issue FSM with latency counter; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rd_q      <= '0;
      alu_op_q  <= OP_FADD;
      alu_x1_q  <= '0;
      alu_x2_q  <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.instr_valid) begin
            if (is_legal_op(bus.instr_op)) begin
              rd_q     <= bus.instr_rd;
              alu_op_q <= bus.instr_op;
              alu_x1_q <= rs1_data;
              alu_x2_q <= rs2_data;
              cnt_q    <= CNT_INIT;
              state_q  <= ST_WAIT;
            end else begin
              // Rejected opcode retires immediately; ALU drive is untouched.
              done_q    <= 1'b1;
              illegal_q <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd1) begin
            result_q <= bus.alu_x3;
            done_q   <= 1'b1;
            cnt_q    <= '0;
            state_q  <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.instr_ready = (state_q == ST_IDLE);
  assign bus.alu_op      = alu_op_q;
  assign bus.alu_x1      = alu_x1_q;
  assign bus.alu_x2      = alu_x2_q;
  assign bus.result      = result_q;
  assign bus.done        = done_q;
  assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: a register-level reference model
// predicts retire cycles and register contents, a monitor checks outputs.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int    LAT = 2;
  localparam int    DLI = (LAT > 1) ? LAT - 2 : 0;
  localparam word_t INF = 32'h7F800000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_ctrl_if bus();

  alu_issue_ctrl #(.ALU_LAT(LAT), .NREG(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state.
  word_t mrf [8];
  typedef struct { int cyc; bit ill; } exp_t;
  exp_t  sbq [$];
  bit    pend_v = 1'b0;
  int    pend_cyc = 0;
  reg_addr_t pend_rd;
  word_t pend_val;
  bit    acc_v = 1'b0;
  bit    acc_ill;
  opcode_t acc_op;
  word_t acc_x1, acc_x2;
  reg_addr_t acc_rd;
  opcode_t exp_op = 3'b000;
  word_t exp_x1 = '0, exp_x2 = '0, exp_res = '0;

  // Stand-in ALU arithmetic: integer ops for the float codes (the controller
  // is opcode-agnostic), with inf*inf giving inf.
  function automatic word_t alu_ref(input opcode_t op, input word_t a, input word_t b);
    case (op)
      OP_FADD: return a + b;
      OP_FSUB: return a - b;
      OP_FMUL: return (a == INF && b == INF) ? INF : a * b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  // ALU environment: result becomes valid LAT cycles after operand edge.
  word_t dl [0:15];
  always @(posedge clk) begin
    dl[0] <= alu_ref(bus.alu_op, bus.alu_x1, bus.alu_x2);
    for (int i = 1; i < 16; i++) dl[i] <= dl[i-1];
  end
  assign bus.alu_x3 = (LAT == 1) ? alu_ref(bus.alu_op, bus.alu_x1, bus.alu_x2) : dl[DLI];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model advance at each clock edge: host write, then writeback (wins),
  // then the instruction accepted on this edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      if (bus.wr_en) mrf[bus.wr_addr] = bus.wr_data;
      if (pend_v && cyc == pend_cyc) begin
        mrf[pend_rd] = pend_val;
        exp_res = pend_val;
        pend_v = 1'b0;
      end
      if (acc_v) begin
        acc_v = 1'b0;
        if (acc_ill) begin
          sbq.push_back('{cyc: cyc, ill: 1'b1});
        end else begin
          exp_op   = acc_op;
          exp_x1   = acc_x1;
          exp_x2   = acc_x2;
          pend_v   = 1'b1;
          pend_cyc = cyc + LAT;
          pend_rd  = acc_rd;
          pend_val = alu_ref(acc_op, acc_x1, acc_x2);
          sbq.push_back('{cyc: cyc + LAT, ill: 1'b0});
        end
      end
    end
  end

  // Monitor: compares outputs with the model every cycle, pops on done.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      chk("instr_ready", 32'(bus.instr_ready), 32'(!pend_v));
      chk("alu_op", 32'(bus.alu_op), 32'(exp_op));
      chk("alu_x1", bus.alu_x1, exp_x1);
      chk("alu_x2", bus.alu_x2, exp_x2);
      chk("result", bus.result, exp_res);
      if (bus.done) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
        end else begin
          e = sbq.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("illegal", 32'(bus.illegal), 32'(e.ill));
        end
      end else begin
        chk("illegal_without_done", 32'(bus.illegal), 32'd0);
      end
      if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL missing_done: got none expected done at cycle %0d", sbq[0].cyc);
        void'(sbq.pop_front());
      end
    end
  end

  // All stimulus tasks are entered and left at a falling edge.
  task automatic host_write(input reg_addr_t a, input word_t d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic issue(input opcode_t op, input reg_addr_t rs1, input reg_addr_t rs2, input reg_addr_t rd);
    int n = 0;
    bus.instr_valid = 1'b1; bus.instr_op = op;
    bus.instr_rs1 = rs1; bus.instr_rs2 = rs2; bus.instr_rd = rd;
    while (pend_v && n <= 50) begin
      @(negedge clk);
      n++;
    end
    if (n > 50) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout: got busy expected idle within 50 cycles");
    end
    acc_ill = !is_legal_op(op);
    acc_op  = op; acc_x1 = mrf[rs1]; acc_x2 = mrf[rs2]; acc_rd = rd;
    acc_v   = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    $display("issue op=%b rs1=%0d rs2=%0d rd=%0d accepted at cycle %0d", op, rs1, rs2, rd, cyc);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (pend_v && n <= 50) begin
      @(negedge clk);
      n++;
    end
    if (n > 50) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: got busy expected idle within 50 cycles");
    end
    @(negedge clk);
  endtask

  task automatic check_reg(input reg_addr_t a, input word_t exp, input string nm);
    bus.rd_addr = a;
    #1;
    chk(nm, bus.rd_data, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"},   32'(bus.instr_ready), 32'd1);
    chk({tag, "_alu_op"},  32'(bus.alu_op), 32'd0);
    chk({tag, "_alu_x1"},  bus.alu_x1, 32'd0);
    chk({tag, "_alu_x2"},  bus.alu_x2, 32'd0);
    chk({tag, "_result"},  bus.result, 32'd0);
    chk({tag, "_done"},    32'(bus.done), 32'd0);
    chk({tag, "_illegal"}, 32'(bus.illegal), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    opcode_t op;
    reg_addr_t a, b, c;
    bus.instr_valid = 1'b0; bus.instr_op = '0;
    bus.instr_rs1 = '0; bus.instr_rs2 = '0; bus.instr_rd = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
    for (int i = 0; i < 8; i++) mrf[i] = '0;

    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    check_reg(3'd5, 32'd0, "por_rf");
    rst_n = 1'b1;
    @(negedge clk);

    // Logic ops, including back-to-back issue in the done cycle.
    host_write(3'd1, 32'hFF8001C0);
    host_write(3'd2, 32'hFF802004);
    issue(OP_AND, 3'd1, 3'd2, 3'd3);
    wait_idle();
    check_reg(3'd3, 32'hFF800000, "and_r3");
    issue(OP_OR, 3'd1, 3'd2, 3'd4);
    issue(OP_XOR, 3'd1, 3'd2, 3'd5);
    wait_idle();
    check_reg(3'd4, 32'hFF8021C4, "or_r4");
    check_reg(3'd5, 32'h000021C4, "xor_r5");

    // Multiply of infinities.
    host_write(3'd1, INF);
    host_write(3'd2, INF);
    issue(OP_FMUL, 3'd1, 3'd2, 3'd6);
    wait_idle();
    check_reg(3'd6, INF, "fmul_r6");

    // Illegal opcodes back-to-back: no writeback, ALU drive unchanged.
    issue(3'b111, 3'd1, 3'd2, 3'd0);
    issue(3'b010, 3'd1, 3'd2, 3'd0);
    wait_idle();
    check_reg(3'd0, 32'd0, "illegal_r0");

    // Host write colliding with the writeback edge.
    issue(OP_FADD, 3'd3, 3'd4, 3'd7);
    while (cyc < pend_cyc - 1) @(negedge clk);
    host_write(3'd7, 32'hDEADBEEF);
    wait_idle();
    check_reg(3'd7, 32'hFF0021C4, "wb_wins_r7");

    // Host write to rs1 while the instruction is in flight.
    issue(OP_FSUB, 3'd5, 3'd4, 3'd2);
    host_write(3'd5, 32'h12345678);
    wait_idle();
    check_reg(3'd2, 32'h00800000, "fsub_r2");
    check_reg(3'd5, 32'h12345678, "host_r5");

    // Reset in the middle of WAIT aborts the instruction.
    bus.rd_addr = 3'd6;
    issue(OP_OR, 3'd1, 3'd2, 3'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midwait");
    chk("midwait_rf", bus.rd_data, 32'd0);
    for (int i = 0; i < 8; i++) mrf[i] = '0;
    sbq.delete();
    pend_v = 1'b0; acc_v = 1'b0;
    exp_op = '0; exp_x1 = '0; exp_x2 = '0; exp_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    check_reg(3'd1, 32'd0, "post_reset_r1");

    // Random instructions interleaved with host writes.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) host_write(3'($urandom_range(0, 7)), $urandom);
      op = 3'($urandom_range(0, 7));
      a  = 3'($urandom_range(0, 7));
      b  = 3'($urandom_range(0, 7));
      c  = 3'($urandom_range(0, 7));
      issue(op, a, b, c);
      if ($urandom_range(0, 2) == 0) host_write(3'($urandom_range(0, 7)), $urandom);
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end
    wait_idle();
    for (int i = 0; i < 8; i++) check_reg(3'(i), mrf[i], "final_rf");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
